// File: rtl/ring_counter_monitor.sv
// Receive-side checker for a one-hot ring pattern arriving asynchronously on the IO pads.
// Latency: a stable ring_in value appears on pos_out/pos_valid 3 clock edges after it is first sampled.
// Backpressure: none; this is a passive monitor and accepts a new sample every clock.
module ring_counter_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int STALL_MAX  = 255,
  parameter bit SHIFT_LEFT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           ring_in,
  input  logic                       clear,
  output logic [$clog2(WIDTH)-1:0]   pos_out,
  output logic                       pos_valid,
  output logic                       locked,
  output logic                       err_pulse,
  output logic                       err_sticky,
  output logic [15:0]                err_count,
  output logic [WIDTH-1:0]           io_oeb
);

  localparam int PW = $clog2(WIDTH);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int IW = $clog2(STALL_MAX + 1);
  // Terminal values are compared before incrementing, so no extra carry bit is needed.
  localparam logic [GW-1:0] LOCK_LAST  = GW'(LOCK_COUNT - 1);
  localparam logic [IW-1:0] STALL_LAST = IW'(STALL_MAX - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  logic [WIDTH-1:0] s1, s2, s3;
  logic [WIDTH-1:0] expected;
  logic             change, onehot, good;
  logic [PW-1:0]    pos_dec;

  state_t           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             err_evt;

  // Pads are only ever inputs here.
  assign io_oeb = '1;

  // s1/s2 form the synchronizer; s3 keeps the previous synchronized sample for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= ring_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  generate
    if (SHIFT_LEFT) begin : g_left
      assign expected = {s3[WIDTH-2:0], s3[WIDTH-1]};
    end else begin : g_right
      assign expected = {s3[0], s3[WIDTH-1:1]};
    end
  endgenerate

  assign change = (s2 != s3);
  assign onehot = ($countones(s2) == 1);
  assign good   = change && onehot && (s2 == expected);

  // One-hot to binary; only meaningful when onehot is true.
  always_comb begin
    pos_dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2[i]) pos_dec = PW'(i);
    end
  end

  // Position output follows the synchronized sample and holds its last value on bad patterns.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_out   <= '0;
      pos_valid <= 1'b0;
    end else begin
      pos_valid <= onehot;
      if (onehot) pos_out <= pos_dec;
    end
  end

  // FSM state and its counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      good_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      idle_q  <= idle_d;
    end
  end

  // Next-state logic: acquire, count good steps to lock, then police steps and stalls.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    idle_d  = idle_q;
    case (state_q)
      ST_HUNT: begin
        if (onehot) begin
          state_d = ST_TRACK;
          good_d  = '0;
        end
      end
      ST_TRACK: begin
        if (!onehot || (change && !good)) begin
          state_d = ST_HUNT;
        end else if (good) begin
          if (good_q == LOCK_LAST) begin
            state_d = ST_LOCKED;
            idle_d  = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (!onehot || (change && !good)) begin
          state_d = ST_ERROR;
        end else if (good) begin
          idle_d = '0;
        end else if (idle_q == STALL_LAST) begin
          state_d = ST_ERROR;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      ST_ERROR: begin
        state_d = ST_HUNT;
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  assign err_evt   = (state_d == ST_ERROR);
  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = (state_q == ST_ERROR);

  // Error bookkeeping; a simultaneous error beats clear, leaving a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_evt) begin
      err_sticky <= 1'b1;
      if (clear)                    err_count <= 16'd1;
      else if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end else if (clear) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end
  end

endmodule

// File: doc/ring_counter_monitor.md
Name: ring_counter_monitor

Overview:
- Receive-side checker for the one-hot ring-counter pattern driven onto the user IO pads.
- Samples the ring bits on io_in through a 2-flop synchronizer and decodes the active position to binary.
- Verifies that every change advances exactly one position, tracks lock/error state, and counts sequence errors.
- Instantiated in user_project_wrapper on the input side, for loopback or board-to-board test of the ring_counter output.

Parameters:
- WIDTH, 4, number of ring bits; must be >= 2.
- LOCK_COUNT, 4, consecutive correct transitions required to declare lock; must be >= 1.
- STALL_MAX, 255, idle cycles tolerated while locked before a stall error; must be >= 1.
- SHIFT_LEFT, 1, expected direction: 1 = bit i to bit i+1 with MSB wrapping to bit 0; 0 = the reverse.

Ports:
- Clock  input  1  single clock (wb_clk_i in the wrapper).
- Reset  input  1  synchronous, active-high reset.
- Ring_in  input  WIDTH  asynchronous ring pattern from io_in.
- Clear  input  1  synchronous; zeroes Err_count and Err_sticky.
- Pos_out  output  clog2(WIDTH)  binary index of the active ring bit.
- Pos_valid  output  1  synchronized sample is exactly one-hot.
- Locked  output  1  FSM is in LOCKED.
- Err_pulse  output  1  one-cycle pulse per detected error.
- Err_sticky  output  1  set by any error; cleared by Clear or Reset.
- Err_count  output  16  saturating error count.
- Io_oeb  output  WIDTH  constant all-ones (pads used as inputs).

Behaviour:
- Reset: Reset is synchronous and active-high. On any edge where Reset=1, all registers clear and the FSM enters HUNT. Resulting outputs: Pos_out=0, Pos_valid=0, Locked=0, Err_pulse=0, Err_sticky=0, Err_count=0. Io_oeb stays all-ones at all times. Reset mid-operation discards lock and counts immediately.
- Pipeline:
  - s1 <= Ring_in; s2 <= s1; s3 <= s2.
  - change = (s2 != s3); onehot = popcount(s2) == 1.
  - expected = s3 rotated one place in the SHIFT_LEFT direction.
  - good = change && onehot && (s2 == expected).
- Pos_out and Pos_valid are registered from s2. A stable Ring_in value is reflected 3 edges after it is first sampled. When s2 is not one-hot, Pos_valid=0 and Pos_out holds its last value.
- FSM (one transition per clock; registered outputs update on the same edge as the state):
  - HUNT: onehot -> TRACK, good_cnt=0.
  - TRACK:
    - !onehot -> HUNT.
    - change && !good -> HUNT (no error: not yet locked).
    - good -> good_cnt+1; if good_cnt+1 == LOCK_COUNT -> LOCKED, idle=0.
    - no change -> stay.
  - LOCKED:
    - good -> idle=0, stay.
    - no change -> idle+1; if idle+1 == STALL_MAX -> ERROR.
    - !onehot, or change && !good -> ERROR.
  - ERROR: lasts exactly 1 cycle, then HUNT.
- Locked=1 only while the FSM is in LOCKED.
- Entering ERROR: Err_pulse=1 for that single cycle, Err_sticky<=1, Err_count<=Err_count+1, saturating at 0xFFFF with no wrap.
- Clear while entering ERROR: the error wins for Err_sticky, which ends at 1. Err_count is set to 1, not 0.
- Wrap-around: MSB->bit0 (SHIFT_LEFT=1) is a good transition.
- A ring counter stepping every clock yields change on every cycle; idle never increments.

Test Plan:
- Reset held 3 cycles, then Ring_in=0000 for 10 cycles -> Pos_valid=0, Locked=0, Err_count=0, Io_oeb=1111.
- Ring_in stepping 0001,0010,0100,1000,0001,... every clock, LOCK_COUNT=4 -> Pos_out sequence 0,1,2,3,0 with 3-cycle latency; Locked rises after the 4th good transition; Err_pulse never fires across the 1000->0001 wrap.
- While locked, inject 0001->0100 skip -> one-cycle Err_pulse, Err_count=1, Err_sticky=1, Locked falls; resumed clean stepping relocks after 4 good transitions.
- While locked, hold Ring_in=0010 with STALL_MAX=8 -> error after exactly 8 idle cycles, Err_count increments by 1; also apply Ring_in=0110 while locked -> Pos_valid=0 and error.
- Preload Err_count to 0xFFFF by forcing repeated errors -> stays at 0xFFFF; assert Clear -> Err_count=0, Err_sticky=0; assert Clear on the same edge an error occurs -> Err_count=1, Err_sticky=1.
- Assert Reset for 1 cycle while locked -> next cycle Locked=0, Err_count=0, FSM in HUNT; relock requires LOCK_COUNT fresh good transitions.
